// File: rtl/spu_mem_stage.sv
// SPU memory pipeline stage: branch resolution plus a req/ack local-store access FSM.
// Optional MEM_TIMEOUT_EN aborts a local-store access after TIMEOUT_CYC unacknowledged wait cycles.
module spu_mem_stage #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned REG_W       = 7,
    parameter int unsigned LS_ADDR_W   = 18,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   branch,
    input  logic                   zero,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   reg_write_in,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      store_data,
    input  logic [REG_W-1:0]       rt_in,
    output logic                   pc_source,
    output logic                   ls_req,
    output logic                   ls_we,
    output logic [LS_ADDR_W-5:0]   ls_addr,
    output logic [DATA_W-1:0]      ls_wdata,
    input  logic                   ls_ack,
    input  logic [DATA_W-1:0]      ls_rdata,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      wb_mem_data,
    output logic [DATA_W-1:0]      wb_alu_result,
    output logic [REG_W-1:0]       wb_rt,
    output logic                   wb_reg_write,
    output logic                   wb_mem_to_reg,
    output logic                   mem_err
);

    typedef enum logic [1:0] {StIdle, StWaitRd, StWaitWr} state_e;

    state_e              state;
    logic                accept;
    logic                expired;
    logic [DATA_W-1:0]   pend_alu_result;
    logic [REG_W-1:0]    pend_rt;
    logic                pend_reg_write;

    assign in_ready  = (state == StIdle);
    assign accept    = in_valid & in_ready;
    assign pc_source = accept & branch & zero;

    // Quadword-aligned and wrapped to the local-store size: low nibble and high bits drop out.
    logic unused_addr;
    assign unused_addr = ^{alu_result[3:0], alu_result[DATA_W-1:LS_ADDR_W]};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Abort at the edge ending the TIMEOUT_CYC-th wait cycle; a same-cycle ack wins.
    assign expired = !ls_ack && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    wait_cnt <= '0;
                    if (accept && !mem_write && !mem_read) begin
                        mem_err <= 1'b0;
                    end
                end
                StWaitRd, StWaitWr: begin
                    if (ls_ack) begin
                        mem_err <= 1'b0;
                    end else if (expired) begin
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = |32'(TIMEOUT_CYC);
    assign expired    = 1'b0;
    assign mem_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= StIdle;
            ls_req          <= 1'b0;
            ls_we           <= 1'b0;
            ls_addr         <= '0;
            ls_wdata        <= '0;
            out_valid       <= 1'b0;
            wb_mem_data     <= '0;
            wb_alu_result   <= '0;
            wb_rt           <= '0;
            wb_reg_write    <= 1'b0;
            wb_mem_to_reg   <= 1'b0;
            pend_alu_result <= '0;
            pend_rt         <= '0;
            pend_reg_write  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (mem_write || mem_read) begin
                            // Stash WB fields so wb_* keep their value until completion.
                            pend_alu_result <= alu_result;
                            pend_rt         <= rt_in;
                            pend_reg_write  <= reg_write_in;
                            ls_req          <= 1'b1;
                            ls_we           <= mem_write;
                            ls_addr         <= alu_result[LS_ADDR_W-1:4];
                            ls_wdata        <= store_data;
                            state           <= mem_write ? StWaitWr : StWaitRd;
                        end else begin
                            wb_alu_result <= alu_result;
                            wb_rt         <= rt_in;
                            wb_reg_write  <= reg_write_in;
                            wb_mem_to_reg <= 1'b0;
                            out_valid     <= 1'b1;
                        end
                    end
                end
                StWaitRd, StWaitWr: begin
                    if (ls_ack || expired) begin
                        ls_req        <= 1'b0;
                        out_valid     <= 1'b1;
                        wb_alu_result <= pend_alu_result;
                        wb_rt         <= pend_rt;
                        state         <= StIdle;
                        if (!ls_ack) begin
                            wb_mem_data   <= '0;
                            wb_reg_write  <= 1'b0;
                            wb_mem_to_reg <= 1'b0;
                        end else if (state == StWaitRd) begin
                            wb_mem_data   <= ls_rdata;
                            wb_reg_write  <= pend_reg_write;
                            wb_mem_to_reg <= 1'b1;
                        end else begin
                            wb_reg_write  <= 1'b0;
                            wb_mem_to_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= StIdle;
                    ls_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_mem_stage.sv
// Directed bench for spu_mem_stage; timeout scenario follows MEM_TIMEOUT_EN.
module tb_spu_mem_stage;

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned REG_W     = 7;
    localparam int unsigned LS_ADDR_W = 18;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 branch;
    logic                 zero;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write_in;
    logic [DATA_W-1:0]    alu_result;
    logic [DATA_W-1:0]    store_data;
    logic [REG_W-1:0]     rt_in;
    logic                 pc_source;
    logic                 ls_req;
    logic                 ls_we;
    logic [LS_ADDR_W-5:0] ls_addr;
    logic [DATA_W-1:0]    ls_wdata;
    logic                 ls_ack;
    logic [DATA_W-1:0]    ls_rdata;
    logic                 out_valid;
    logic [DATA_W-1:0]    wb_mem_data;
    logic [DATA_W-1:0]    wb_alu_result;
    logic [REG_W-1:0]     wb_rt;
    logic                 wb_reg_write;
    logic                 wb_mem_to_reg;
    logic                 mem_err;

    int n_checks;
    int n_pass;

    localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};

    spu_mem_stage #(
        .DATA_W      (DATA_W),
        .REG_W       (REG_W),
        .LS_ADDR_W   (LS_ADDR_W),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .branch        (branch),
        .zero          (zero),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write_in  (reg_write_in),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .rt_in         (rt_in),
        .pc_source     (pc_source),
        .ls_req        (ls_req),
        .ls_we         (ls_we),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_ack        (ls_ack),
        .ls_rdata      (ls_rdata),
        .out_valid     (out_valid),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_result (wb_alu_result),
        .wb_rt         (wb_rt),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        branch       = 1'b0;
        zero         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write_in = 1'b0;
        ls_ack       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        alu_result = '0;
        store_data = '0;
        rt_in      = '0;
        ls_rdata   = '0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (ls_req !== 1'b0) $display("FAIL reset_ls_req: got %b want 0", ls_req); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (wb_alu_result !== '0 || ls_addr !== '0 || mem_err !== 1'b0)
            $display("FAIL reset_regs: got alu=%h addr=%h err=%b want 0/0/0", wb_alu_result, ls_addr, mem_err);
        else n_pass++;
    endtask

    task automatic test_alu_op();
        in_valid     = 1'b1;
        alu_result   = 128'h5;
        rt_in        = 7'd3;
        reg_write_in = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL alu_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (wb_alu_result !== 128'h5) $display("FAIL alu_result: got %h want 5", wb_alu_result); else n_pass++;
        n_checks++; if (wb_rt !== 7'd3 || wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b0)
            $display("FAIL alu_ctrl: got rt=%0d rw=%b m2r=%b want 3/1/0", wb_rt, wb_reg_write, wb_mem_to_reg);
        else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL alu_in_ready: got %b want 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || wb_alu_result !== 128'h5)
            $display("FAIL alu_hold: got ov=%b alu=%h want 0/5", out_valid, wb_alu_result);
        else n_pass++;
    endtask

    task automatic test_load();
        int busy;
        in_valid     = 1'b1;
        mem_read     = 1'b1;
        reg_write_in = 1'b1;
        rt_in        = 7'd9;
        alu_result   = 128'h1234F;
        tick();
        idle_inputs();
        n_checks++; if (ls_req !== 1'b1 || ls_we !== 1'b0 || ls_addr !== 14'h1234)
            $display("FAIL load_req: got req=%b we=%b addr=%h want 1/0/1234", ls_req, ls_we, ls_addr);
        else n_pass++;
        busy = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin
                in_valid = 1'b1;
                branch   = 1'b1;
                zero     = 1'b1;
                #1;
                n_checks++; if (pc_source !== 1'b0) $display("FAIL branch_in_wait: got %b want 0", pc_source); else n_pass++;
                idle_inputs();
            end
            if (k == 3) begin
                n_checks++; if (ls_req !== 1'b1 || ls_addr !== 14'h1234)
                    $display("FAIL load_hold: got req=%b addr=%h want 1/1234", ls_req, ls_addr);
                else n_pass++;
            end
            if (k == 4) begin
                ls_ack   = 1'b1;
                ls_rdata = PAT_A5;
            end
            #1;
            if (!in_ready) busy++;
            tick();
        end
        idle_inputs();
        ls_rdata = '0;
        n_checks++; if (busy !== 4) $display("FAIL load_busy_cycles: got %0d want 4", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || ls_req !== 1'b0)
            $display("FAIL load_done: got ov=%b req=%b want 1/0", out_valid, ls_req);
        else n_pass++;
        n_checks++; if (wb_mem_data !== PAT_A5) $display("FAIL load_data: got %h want %h", wb_mem_data, PAT_A5); else n_pass++;
        n_checks++; if (wb_mem_to_reg !== 1'b1 || wb_reg_write !== 1'b1 || wb_rt !== 7'd9)
            $display("FAIL load_ctrl: got m2r=%b rw=%b rt=%0d want 1/1/9", wb_mem_to_reg, wb_reg_write, wb_rt);
        else n_pass++;
        tick();
    endtask

    task automatic test_store_back_to_back();
        in_valid     = 1'b1;
        mem_write    = 1'b1;
        mem_read     = 1'b1;
        reg_write_in = 1'b1;
        alu_result   = 128'h20;
        store_data   = 128'hDEAD;
        tick();
        idle_inputs();
        n_checks++; if (ls_req !== 1'b1 || ls_we !== 1'b1 || ls_addr !== 14'h2)
            $display("FAIL store_req: got req=%b we=%b addr=%h want 1/1/2", ls_req, ls_we, ls_addr);
        else n_pass++;
        n_checks++; if (ls_wdata !== 128'hDEAD) $display("FAIL store_wdata: got %h want dead", ls_wdata); else n_pass++;
        ls_ack = 1'b1;
        tick();
        ls_ack = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0)
            $display("FAIL store_done: got ov=%b rw=%b m2r=%b want 1/0/0", out_valid, wb_reg_write, wb_mem_to_reg);
        else n_pass++;
        // New op accepted in the same cycle the store completes.
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else n_pass++;
        in_valid   = 1'b1;
        mem_read   = 1'b1;
        alu_result = 128'h1_0000_0000_0007_FFF3;
        tick();
        idle_inputs();
        n_checks++; if (ls_req !== 1'b1 || ls_addr !== 14'h3FFF)
            $display("FAIL addr_wrap: got req=%b addr=%h want 1/3fff", ls_req, ls_addr);
        else n_pass++;
        ls_ack   = 1'b1;
        ls_rdata = 128'h42;
        tick();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1 || wb_mem_data !== 128'h42)
            $display("FAIL min_latency: got ov=%b data=%h want 1/42", out_valid, wb_mem_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch();
        in_valid = 1'b1;
        branch   = 1'b1;
        zero     = 1'b1;
        #1;
        n_checks++; if (pc_source !== 1'b1) $display("FAIL branch_taken: got %b want 1", pc_source); else n_pass++;
        zero = 1'b0;
        #1;
        n_checks++; if (pc_source !== 1'b0) $display("FAIL branch_not_taken: got %b want 0", pc_source); else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_access();
        int ov_seen;
        in_valid   = 1'b1;
        mem_read   = 1'b1;
        alu_result = 128'h100;
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ls_ack = 1'b1;
        ov_seen = 0;
        n_checks++; if (ls_req !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset_state: got req=%b ready=%b want 0/1", ls_req, in_ready);
        else n_pass++;
        if (out_valid) ov_seen++;
        tick();
        ls_ack = 1'b0;
        if (out_valid) ov_seen++;
        tick();
        if (out_valid) ov_seen++;
        n_checks++; if (ov_seen !== 0) $display("FAIL stray_ack_ov: got %0d pulses want 0", ov_seen); else n_pass++;
        n_checks++; if (ls_req !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stray_ack_state: got req=%b ready=%b want 0/1", ls_req, in_ready);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int ov_seen;
        in_valid     = 1'b1;
        mem_read     = 1'b1;
        reg_write_in = 1'b1;
        alu_result   = 128'h300;
        tick();
        idle_inputs();
        ov_seen = 0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        tick();
        n_checks++; if (ov_seen !== 0) $display("FAIL timeout_early: got %0d pulses want 0", ov_seen); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || mem_err !== 1'b1 || ls_req !== 1'b0)
            $display("FAIL timeout_abort: got ov=%b err=%b req=%b want 1/1/0", out_valid, mem_err, ls_req);
        else n_pass++;
        n_checks++; if (wb_mem_data !== '0 || wb_reg_write !== 1'b0)
            $display("FAIL timeout_wb: got data=%h rw=%b want 0/0", wb_mem_data, wb_reg_write);
        else n_pass++;
        tick();
        in_valid = 1'b1;
        mem_read = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        ls_ack   = 1'b1;
        ls_rdata = 128'h77;
        tick();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1 || mem_err !== 1'b0 || wb_mem_data !== 128'h77)
            $display("FAIL ack_on_expiry: got ov=%b err=%b data=%h want 1/0/77", out_valid, mem_err, wb_mem_data);
        else n_pass++;
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        n_checks++; if (ov_seen !== 0 || ls_req !== 1'b1)
            $display("FAIL no_timeout_wait: got pulses=%0d req=%b want 0/1", ov_seen, ls_req);
        else n_pass++;
        ls_ack   = 1'b1;
        ls_rdata = 128'h77;
        tick();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1 || mem_err !== 1'b0 || wb_mem_data !== 128'h77)
            $display("FAIL late_ack: got ov=%b err=%b data=%h want 1/0/77", out_valid, mem_err, wb_mem_data);
        else n_pass++;
`endif
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_alu_op();
        test_load();
        test_store_back_to_back();
        test_branch();
        test_reset_mid_access();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
